// File: rtl/harris_nms_pkg.sv
// Shared constants for the Harris corner pipeline: response width,
// default frame geometry and coordinate width.
package harris_nms_pkg;

    localparam int RESP_BITS  = 18;
    localparam int IMG_WIDTH  = 640;
    localparam int IMG_HEIGHT = 480;
    localparam int COORD_BITS = 10;
    localparam int WIN_SIZE   = 3;

endpackage

// File: rtl/harris_line_buffer.sv
// Single-write-port RAM with a registered read port; one read per cycle.
// A read of an address being written in the same cycle returns the old data.
module harris_line_buffer
    import harris_nms_pkg::*;
#(
    parameter int p_data_bits = 2 * RESP_BITS,
    parameter int p_addr_bits = COORD_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  logic [p_addr_bits-1:0] wr_addr_i,
    input  logic [p_data_bits-1:0] wr_data_i,
    input  logic                   rd_en_i,
    input  logic [p_addr_bits-1:0] rd_addr_i,
    output logic [p_data_bits-1:0] rd_data_o
);

    logic [p_data_bits-1:0] mem_q [0:(2**p_addr_bits)-1];
    logic [p_data_bits-1:0] rd_data_q;

    // Storage array write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end else begin
            rd_data_q <= rd_data_q;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/harris_nms.sv
// 3x3 non-maximum suppression and thresholding of a raster stream of Harris
// responses; one registered result per completed window, 3-cycle latency.
module harris_nms
    import harris_nms_pkg::*;
#(
    parameter int p_num_bits_in = RESP_BITS,
    parameter int p_width       = IMG_WIDTH,
    parameter int p_height      = IMG_HEIGHT,
    parameter int p_coord_bits  = COORD_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic signed [p_num_bits_in-1:0] threshold,
    input  logic                            in_valid,
    input  logic                            in_sof,
    input  logic signed [p_num_bits_in-1:0] in_data,
    output logic                            out_valid,
    output logic                            out_corner,
    output logic        [p_coord_bits-1:0]  out_x,
    output logic        [p_coord_bits-1:0]  out_y,
    output logic signed [p_num_bits_in-1:0] out_score
);

    typedef logic        [p_coord_bits-1:0]  coord_t;
    typedef logic signed [p_num_bits_in-1:0] resp_t;

    localparam coord_t ZERO     = coord_t'(0);
    localparam coord_t ONE      = coord_t'(1);
    localparam coord_t LAST_COL = coord_t'(p_width - 1);
    localparam coord_t LAST_ROW = coord_t'(p_height - 1);
    localparam coord_t MAX_X    = coord_t'(p_width - 2);
    localparam coord_t MAX_Y    = coord_t'(p_height - 2);

    coord_t col_q, row_q, col_d, row_d, cur_col_s, cur_row_s;
    logic   v1_q, v2_q;
    coord_t col1_q, row1_q, x2_q, y2_q;
    resp_t  pix1_q, rd_r1_s, rd_r2_s, centre_s;
    resp_t  win_q [0:WIN_SIZE-1][0:WIN_SIZE-1];
    logic [2*p_num_bits_in-1:0] lb_rd_s, lb_wr_s;
    logic   interior_s, earlier_ok_s, later_ok_s, corner_s;
    logic   out_valid_q, out_corner_q;
    coord_t out_x_q, out_y_q;
    resp_t  out_score_q;

    // Position of the pixel on the input this cycle and the one after it.
    always_comb begin
        cur_col_s = in_sof ? ZERO : col_q;
        cur_row_s = in_sof ? ZERO : row_q;
        col_d     = col_q;
        row_d     = row_q;
        if (in_valid) begin
            if (cur_col_s == LAST_COL) begin
                col_d = ZERO;
                row_d = (cur_row_s == LAST_ROW) ? ZERO : cur_row_s + ONE;
            end else begin
                col_d = cur_col_s + ONE;
                row_d = cur_row_s;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Position counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= ZERO;
            row_q <= ZERO;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Stage 1: delayed pixel and its coordinates, aligned with RAM read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q   <= 1'b0;
            col1_q <= ZERO;
            row1_q <= ZERO;
            pix1_q <= '0;
        end else if (in_valid) begin
            v1_q   <= 1'b1;
            col1_q <= cur_col_s;
            row1_q <= cur_row_s;
            pix1_q <= in_data;
        end else begin
            v1_q   <= 1'b0;
            col1_q <= col1_q;
            row1_q <= row1_q;
            pix1_q <= pix1_q;
        end
    end

    // One RAM word per column packs {row r-2, row r-1}; the write-back ages both rows.
    assign rd_r1_s = lb_rd_s[p_num_bits_in-1:0];
    assign rd_r2_s = lb_rd_s[2*p_num_bits_in-1:p_num_bits_in];
    assign lb_wr_s = {rd_r1_s, pix1_q};

    harris_line_buffer #(
        .p_data_bits (2 * p_num_bits_in),
        .p_addr_bits (p_coord_bits)
    ) u_line_buffer (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (v1_q),
        .wr_addr_i (col1_q),
        .wr_data_i (lb_wr_s),
        .rd_en_i   (in_valid),
        .rd_addr_i (cur_col_s),
        .rd_data_o (lb_rd_s)
    );

    // Stage 2: shift the 3x3 window left and register the centre coordinates.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_q <= 1'b0;
            x2_q <= ZERO;
            y2_q <= ZERO;
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (v1_q) begin
            v2_q <= (col1_q != ZERO) && (row1_q != ZERO);
            x2_q <= col1_q - ONE;
            y2_q <= row1_q - ONE;
            for (int r = 0; r < WIN_SIZE; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= rd_r2_s;
            win_q[1][2] <= rd_r1_s;
            win_q[2][2] <= pix1_q;
        end else begin
            v2_q <= 1'b0;
        end
    end

    // Raster-earlier neighbours may tie the centre; raster-later ones must be smaller.
    always_comb begin
        centre_s     = win_q[1][1];
        interior_s   = (x2_q >= ONE) && (x2_q <= MAX_X) && (y2_q >= ONE) && (y2_q <= MAX_Y);
        earlier_ok_s = (centre_s >= win_q[0][0]) && (centre_s >= win_q[0][1]) &&
                       (centre_s >= win_q[0][2]) && (centre_s >= win_q[1][0]);
        later_ok_s   = (centre_s >  win_q[1][2]) && (centre_s >  win_q[2][0]) &&
                       (centre_s >  win_q[2][1]) && (centre_s >  win_q[2][2]);
        corner_s     = 1'b0;
        if (interior_s && (centre_s > threshold) && earlier_ok_s && later_ok_s) begin
            corner_s = 1'b1;
        end else begin
            corner_s = 1'b0;
        end
    end

    // Output registers; fields hold while no result is being emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_corner_q <= 1'b0;
            out_x_q      <= ZERO;
            out_y_q      <= ZERO;
            out_score_q  <= '0;
        end else if (v2_q) begin
            out_valid_q  <= 1'b1;
            out_corner_q <= corner_s;
            out_x_q      <= x2_q;
            out_y_q      <= y2_q;
            out_score_q  <= centre_s;
        end else begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_corner = out_corner_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_score  = out_score_q;

endmodule

// File: tb/tb_harris_nms.sv
// Directed bench for harris_nms on an 8x6 frame: hand-coded frames and
// hand-computed corner expectations, checked with immediate assertions.
module tb_harris_nms;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = 18;
    localparam int CB = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [N-1:0]  threshold;
    logic                 in_valid;
    logic                 in_sof;
    logic signed [N-1:0]  in_data;
    logic                 out_valid;
    logic                 out_corner;
    logic [CB-1:0]        out_x;
    logic [CB-1:0]        out_y;
    logic signed [N-1:0]  out_score;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    int exp_x[$], exp_y[$], exp_t[$], exp_s[$], exp_c[$];
    logic signed [31:0] got_x[$], got_y[$], got_s[$], got_c[$];
    int got_t[$];

    harris_nms #(
        .p_num_bits_in (N),
        .p_width       (W),
        .p_height      (H),
        .p_coord_bits  (CB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .threshold  (threshold),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_corner (out_corner),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_score  (out_score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every emitted result together with the cycle it appeared in.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            got_x.push_back(32'(out_x));
            got_y.push_back(32'(out_y));
            got_s.push_back(32'($signed(out_score)));
            got_c.push_back(32'(out_corner));
            got_t.push_back(cyc);
        end
    end

    function automatic int pix(input int tst, input int x, input int y);
        case (tst)
            2, 7, 8, 9: return (x == 3 && y == 2) ? 1000 : 0;
            3:          return ((x == 3 || x == 4) && y == 2) ? 1000 : 0;
            4:          return (x == 3 && y == 2) ? 500 : 0;
            5:          return ((x == 0 && y == 2) || (x == 7 && y == 3)) ? 1000 : 0;
            6:          return (x == 3 && y == 2) ? -5 : -10;
            default:    return 0;
        endcase
    endfunction

    function automatic int corner_at(input int tst, input int x, input int y);
        case (tst)
            2, 6, 7, 8, 9: return (x == 3 && y == 2) ? 1 : 0;
            3:             return (x == 4 && y == 2) ? 1 : 0;
            default:       return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n, input bit sof_noise);
        repeat (n) begin
            in_valid = 1'b0;
            in_sof   = sof_noise;
            in_data  = N'($urandom);
            @(posedge clk);
            #1;
        end
        in_sof = 1'b0;
    endtask

    task automatic put(input int tst, input int x, input int y, input bit sof);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = N'(pix(tst, x, y));
        if (x >= 1 && y >= 1) begin
            exp_x.push_back(x - 1);
            exp_y.push_back(y - 1);
            exp_t.push_back(cyc + 3);
            exp_s.push_back(pix(tst, x - 1, y - 1));
            exp_c.push_back(corner_at(tst, x - 1, y - 1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic run_frame(input int tst, input int gap_max, input int stop_x, input int stop_y, input bit sof0);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (x == stop_x && y == stop_y) return;
                if (gap_max > 0) idle($urandom_range(0, gap_max), 1'b1);
                put(tst, x, y, sof0 && x == 0 && y == 0);
            end
        end
    endtask

    task automatic clear_queues();
        exp_x.delete(); exp_y.delete(); exp_t.delete(); exp_s.delete(); exp_c.delete();
        got_x.delete(); got_y.delete(); got_t.delete(); got_s.delete(); got_c.delete();
    endtask

    task automatic check_frame(input string tag, input int n_corner, input int cx, input int cy, input int cs);
        int n;
        int nc;
        idle(6, 1'b0);
        chk({tag, ".count"}, got_x.size(), exp_x.size());
        n  = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
        nc = 0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d].x", tag, i),      got_x[i], exp_x[i]);
            chk($sformatf("%s[%0d].y", tag, i),      got_y[i], exp_y[i]);
            chk($sformatf("%s[%0d].cycle", tag, i),  got_t[i], exp_t[i]);
            chk($sformatf("%s[%0d].score", tag, i),  got_s[i], exp_s[i]);
            chk($sformatf("%s[%0d].corner", tag, i), got_c[i], exp_c[i]);
            if (got_c[i] === 32'sd1) begin
                nc++;
                if (n_corner == 1) begin
                    chk({tag, ".corner_x"},     got_x[i], cx);
                    chk({tag, ".corner_y"},     got_y[i], cy);
                    chk({tag, ".corner_score"}, got_s[i], cs);
                end
            end
        end
        chk({tag, ".corners"}, nc, n_corner);
        clear_queues();
    endtask

    initial begin
        reset     = 1'b1;
        threshold = N'(500);
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.out_valid",  32'(out_valid),  0);
        chk("reset.out_corner", 32'(out_corner), 0);
        chk("reset.out_x",      32'(out_x),      0);
        chk("reset.out_y",      32'(out_y),      0);
        chk("reset.out_score",  32'(out_score),  0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        threshold = N'(0);
        run_frame(1, 0, -1, -1, 1'b1);
        check_frame("zero", 0, 0, 0, 0);

        threshold = N'(500);
        run_frame(2, 0, -1, -1, 1'b1);
        check_frame("single", 1, 3, 2, 1000);

        run_frame(3, 0, -1, -1, 1'b1);
        check_frame("plateau", 1, 4, 2, 1000);

        run_frame(4, 0, -1, -1, 1'b1);
        check_frame("at_threshold", 0, 0, 0, 0);

        run_frame(5, 0, -1, -1, 1'b1);
        check_frame("border", 0, 0, 0, 0);

        threshold = -N'(8);
        run_frame(6, 0, -1, -1, 1'b1);
        check_frame("negative", 1, 3, 2, -5);
        threshold = N'(500);

        run_frame(7, 3, -1, -1, 1'b1);
        check_frame("gaps", 1, 3, 2, 1000);

        // Reset lands on pixel (2,3); the next frame is sent without in_sof.
        run_frame(8, 0, 2, 3, 1'b1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = N'(pix(8, 2, 3));
        @(posedge clk);
        @(negedge clk);
        chk("midreset.out_valid", 32'(out_valid), 0);
        chk("midreset.out_x",     32'(out_x),     0);
        chk("midreset.out_score", 32'(out_score), 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        clear_queues();
        run_frame(8, 0, -1, -1, 1'b0);
        check_frame("after_reset", 1, 3, 2, 1000);

        // in_sof restarts the frame at (2,3); earlier in-flight results still emerge.
        run_frame(9, 0, 2, 3, 1'b1);
        run_frame(9, 0, -1, -1, 1'b1);
        check_frame("sof_restart", 1, 3, 2, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
